vga_frame_analyzer: RTL and testbench

VGA_FRAME_ANALYZER -- requirements
Module: vga_frame_analyzer

---
 rtl/vga_frame_analyzer.sv | 220 ++++++++++++++++++++++
 tb/tb_vga_frame_analyzer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_analyzer.sv
// VGA frame analyzer: recovers raster position from hsync/vsync, locks to the timing and reports
// per-frame bounding box of white pixels; one-cycle decode latency, no backpressure (streaming input).
// Optional white-pixel count is enabled with macro VGA_FRAME_ANALYZER_PIXCNT_EN.
module vga_frame_analyzer #(
  parameter int X_MIN       = 32,
  parameter int LOCK_FRAMES = 2,
  parameter int H_VISIBLE   = 640,
  parameter int H_SYNC      = 656,
  parameter int H_TOTAL     = 800,
  parameter int V_VISIBLE   = 480,
  parameter int V_SYNC      = 490,
  parameter int V_TOTAL     = 525
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in,
  output logic        locked,
  output logic        sync_err,
  output logic        frame_done,
  output logic        obj_found,
  output logic [9:0]  obj_x_min,
  output logic [9:0]  obj_x_max,
  output logic [9:0]  obj_y_min,
  output logic [9:0]  obj_y_max,
  output logic [18:0] obj_pixels
);

  localparam logic [9:0] H_VIS_L  = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_L = 10'(H_SYNC);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_VIS_L  = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_L = 10'(V_SYNC);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_MIN_L  = 10'(X_MIN);
  localparam int CW = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {SEARCH, ACQ, LOCKED} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] frm_cnt, frm_cnt_nxt;

  logic [7:0] s1;
  logic [1:0] sync_d;
  logic [9:0] h_cnt, v_cnt, h_nxt, v_nxt, pos_h, pos_v;
  logic       hs_rise, vs_rise, err_c, frame_end, counted;

  logic       acc_found;
  logic [9:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= '0;
      sync_d <= '0;
      h_cnt  <= '0;
      v_cnt  <= '0;
    end else begin
      s1     <= vga_in;
      sync_d <= s1[1:0];
      h_cnt  <= h_nxt;
      v_cnt  <= v_nxt;
    end
  end

  assign hs_rise = s1[0] & ~sync_d[0];
  assign vs_rise = s1[1] & ~sync_d[1];

  // pos_h/pos_v is the position of the s1 sample after applying any sync reload;
  // the vsync reload overrides both the hsync reload and the line wrap.
  always_comb begin
    pos_h = h_cnt;
    pos_v = v_cnt;
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (vs_rise) begin
      pos_h = '0;
      pos_v = V_SYNC_L;
      h_nxt = 10'd1;
      v_nxt = V_SYNC_L;
    end else if (hs_rise) begin
      pos_h = H_SYNC_L;
      h_nxt = H_SYNC_L + 10'd1;
    end else if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_nxt = h_cnt + 10'd1;
    end
  end

  assign err_c = (hs_rise && (h_cnt != H_SYNC_L)) ||
                 (vs_rise && ((v_cnt != V_SYNC_L) || (h_cnt != 10'd0)));

  assign frame_end = (pos_h == 10'd0) && (pos_v == V_VIS_L);
  assign counted   = (pos_h < H_VIS_L) && (pos_v < V_VIS_L) &&
                     (pos_h >= X_MIN_L) && (&s1[7:2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SEARCH;
      frm_cnt <= '0;
    end else begin
      state   <= state_nxt;
      frm_cnt <= frm_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    frm_cnt_nxt = frm_cnt;
    case (state)
      SEARCH: begin
        if (vs_rise) begin
          state_nxt   = ACQ;
          frm_cnt_nxt = '0;
        end
      end
      ACQ: begin
        if (err_c) begin
          frm_cnt_nxt = '0;
        end else if (vs_rise) begin
          if (frm_cnt == CNT_LAST) begin
            state_nxt   = LOCKED;
            frm_cnt_nxt = '0;
          end else begin
            frm_cnt_nxt = frm_cnt + 1'b1;
          end
        end
      end
      LOCKED: begin
        if (err_c) begin
          state_nxt   = SEARCH;
          frm_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt   = SEARCH;
        frm_cnt_nxt = '0;
      end
    endcase
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_err <= 1'b0;
    end else begin
      sync_err <= err_c;
    end
  end

  // The frame-end sample is never visible, so re-initialising there loses no pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_found <= 1'b0;
      acc_xmin  <= 10'd1023;
      acc_xmax  <= '0;
      acc_ymin  <= 10'd1023;
      acc_ymax  <= '0;
    end else if (frame_end) begin
      acc_found <= 1'b0;
      acc_xmin  <= 10'd1023;
      acc_xmax  <= '0;
      acc_ymin  <= 10'd1023;
      acc_ymax  <= '0;
    end else if (counted) begin
      acc_found <= 1'b1;
      if (pos_h < acc_xmin) acc_xmin <= pos_h;
      if (pos_h > acc_xmax) acc_xmax <= pos_h;
      if (pos_v < acc_ymin) acc_ymin <= pos_v;
      if (pos_v > acc_ymax) acc_ymax <= pos_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      obj_found  <= 1'b0;
      obj_x_min  <= '0;
      obj_x_max  <= '0;
      obj_y_min  <= '0;
      obj_y_max  <= '0;
    end else begin
      frame_done <= frame_end && locked;
      if (frame_end && locked) begin
        obj_found <= acc_found;
        obj_x_min <= acc_found ? acc_xmin : 10'd0;
        obj_x_max <= acc_found ? acc_xmax : 10'd0;
        obj_y_min <= acc_found ? acc_ymin : 10'd0;
        obj_y_max <= acc_found ? acc_ymax : 10'd0;
      end
    end
  end

`ifdef VGA_FRAME_ANALYZER_PIXCNT_EN
  logic [18:0] acc_pix, pix_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_pix <= '0;
      pix_q   <= '0;
    end else begin
      if (frame_end) begin
        acc_pix <= '0;
      end else if (counted && (acc_pix != '1)) begin
        acc_pix <= acc_pix + 19'd1;
      end
      if (frame_end && locked) begin
        pix_q <= acc_pix;
      end
    end
  end

  assign obj_pixels = pix_q;
`else
  assign obj_pixels = '0;
`endif

endmodule

// File: tb/tb_vga_frame_analyzer.sv
// Scoreboard bench for vga_frame_analyzer on a scaled raster; expected frame results come from
// a pixel-map model, a monitor compares them whenever frame_done fires.
`timescale 1ns/1ps
module tb_vga_frame_analyzer;
  localparam int HV = 40, HS = 48, HW = 8, HT = 64;
  localparam int VV = 24, VS = 27, VT = 32;
  localparam int XMIN = 8, LF = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  vga_in = '0;
  logic        locked, sync_err, frame_done, obj_found;
  logic [9:0]  obj_x_min, obj_x_max, obj_y_min, obj_y_max;
  logic [18:0] obj_pixels;

  vga_frame_analyzer #(
    .X_MIN(XMIN), .LOCK_FRAMES(LF),
    .H_VISIBLE(HV), .H_SYNC(HS), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_SYNC(VS), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vga_in(vga_in),
    .locked(locked), .sync_err(sync_err), .frame_done(frame_done),
    .obj_found(obj_found), .obj_x_min(obj_x_min), .obj_x_max(obj_x_max),
    .obj_y_min(obj_y_min), .obj_y_max(obj_y_max), .obj_pixels(obj_pixels)
  );

  always #20 clk = ~clk;

  typedef struct {
    int found;
    int xmin, xmax, ymin, ymax;
    int pix;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, err_seen = 0, exp_err = 0;
  bit   img [VV][HV];
  bit   m_first = 0, m_locked = 0;
  int   m_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sync_err) err_seen++;
    if (frame_done) begin
      if (sb.size() == 0) begin
        chk("frame_done_unexpected", int'(frame_done), 0);
      end else begin
        e = sb.pop_front();
        chk("frame_done_cycle", cyc, e.cyc);
        chk("obj_found", int'(obj_found), e.found);
        chk("obj_x_min", int'(obj_x_min), e.xmin);
        chk("obj_x_max", int'(obj_x_max), e.xmax);
        chk("obj_y_min", int'(obj_y_min), e.ymin);
        chk("obj_y_max", int'(obj_y_max), e.ymax);
        chk("obj_pixels", int'(obj_pixels), e.pix);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_sync_err"}, int'(sync_err), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_obj_found"}, int'(obj_found), 0);
    chk({tag, "_bbox_or"}, int'(obj_x_min | obj_x_max | obj_y_min | obj_y_max), 0);
    chk({tag, "_obj_pixels"}, int'(obj_pixels), 0);
  endtask

  task automatic clear_img();
    for (int y = 0; y < VV; y++)
      for (int x = 0; x < HV; x++) img[y][x] = 1'b0;
  endtask

  task automatic box(input int x0, input int y0, input int w, input int h);
    for (int y = y0; y < y0 + h; y++)
      for (int x = x0; x < x0 + w; x++)
        if (x < HV && y < VV) img[y][x] = 1'b1;
  endtask

  task automatic fill_random();
    clear_img();
    repeat ($urandom_range(1, 10)) img[$urandom_range(0, VV-1)][$urandom_range(0, HV-1)] = 1'b1;
    if ($urandom_range(0, 1) == 1)
      box($urandom_range(0, HV-1), $urandom_range(0, VV-1), $urandom_range(1, 6), $urandom_range(1, 6));
  endtask

  // Expected result straight from the white-pixel map, counting only columns >= XMIN.
  task automatic model_frame(output exp_t e);
    int n;
    n = 0;
    e.found = 0; e.xmin = HV; e.xmax = -1; e.ymin = VV; e.ymax = -1; e.cyc = 0;
    for (int y = 0; y < VV; y++)
      for (int x = XMIN; x < HV; x++)
        if (img[y][x]) begin
          e.found = 1;
          n++;
          if (x < e.xmin) e.xmin = x;
          if (x > e.xmax) e.xmax = x;
          if (y < e.ymin) e.ymin = y;
          if (y > e.ymax) e.ymax = y;
        end
    if (e.found == 0) begin
      e.xmin = 0; e.xmax = 0; e.ymin = 0; e.ymax = 0;
    end
`ifdef VGA_FRAME_ANALYZER_PIXCNT_EN
    e.pix = n;
`else
    e.pix = 0;
`endif
  endtask

  function automatic logic [7:0] pix(input int h, input int v);
    logic [5:0] c;
    logic       hs, vs;
    hs = (h >= HS) && (h < HS + HW);
    vs = (v == VS) || (v == VS + 1);
    c  = 6'($urandom);
    if (v < VV && h < HV) begin
      if (img[v][h]) c = 6'h3f;
      else if (c == 6'h3f) c = 6'h3c;
    end
    return {c, vs, hs};
  endfunction

  // first: release reset aligned so the first captured sample is (1,0).
  // short_line: that line loses its last clock. abort_line: reset asserted at its start.
  task automatic send_frame(input bit first, input int short_line, input int abort_line);
    exp_t e;
    model_frame(e);
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        if (first && v == 0 && h == 0) continue;
        if (v == short_line && h == HT - 1) continue;
        @(posedge clk);
        #1;
        if (v == abort_line) begin
          rst_n = 1'b0;
          #1;
          check_all_zero("midframe_reset");
          m_first = 0; m_run = 0; m_locked = 0;
          return;
        end
        if (first && v == 0 && h == 1) rst_n = 1'b1;
        vga_in = pix(h, v);
        if (v == VV && h == 0 && m_locked) begin
          e.cyc = cyc + 2;
          sb.push_back(e);
        end
      end
    end
    // Lock rules: a timing error drops lock (back to search) or restarts the good-frame run;
    // the first vsync after search only arms acquisition; LF further clean vsyncs lock.
    if (short_line >= 0) begin
      exp_err++;
      m_run = 0;
      if (m_locked) begin
        m_locked = 0;
        m_first  = 0;
      end
    end
    if (!m_first) begin
      m_first = 1;
      m_run   = 0;
    end else if (!m_locked) begin
      m_run++;
      if (m_run == LF) m_locked = 1;
    end
    chk("locked_after_frame", int'(locked), int'(m_locked));
    chk("sync_err_count", err_seen, exp_err);
  endtask

  initial begin
    #50;
    check_all_zero("reset");
    clear_img();
    send_frame(1, -1, -1);
    send_frame(0, -1, -1);
    send_frame(0, -1, -1);
    send_frame(0, -1, -1);
    clear_img(); box(20, 12, 5, 5); box(2, 10, 4, 12);
    send_frame(0, -1, -1);
    clear_img(); box(35, 19, 8, 8);
    send_frame(0, -1, -1);
    clear_img(); box(XMIN - 1, 3, 1, 1); box(XMIN, 7, 1, 1);
    send_frame(0, -1, -1);
    clear_img(); box(0, 0, XMIN, VV);
    send_frame(0, -1, -1);
    for (int i = 0; i < 3; i++) begin
      fill_random();
      send_frame(0, -1, -1);
    end
    fill_random();
    send_frame(0, VV + 1, -1);
    fill_random();
    send_frame(0, -1, -1);
    fill_random();
    send_frame(0, -1, -1);
    clear_img(); box(20, 12, 5, 5);
    send_frame(0, -1, -1);
    send_frame(0, -1, 10);
    repeat (3) @(posedge clk);
    fill_random();
    send_frame(1, -1, -1);
    for (int i = 0; i < 3; i++) begin
      fill_random();
      send_frame(0, -1, -1);
    end
    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
